// File: rtl/debug_pkg.sv
// Shared encodings for the serial debug command sequencer.
// DEBUG_PC_REPORT_EN adds the two PC-report states.
package debug_pkg;

    localparam logic [7:0] CMD_HALT    = 8'h48;
    localparam logic [7:0] CMD_RESUME  = 8'h52;
    localparam logic [7:0] CMD_STEP    = 8'h53;
    localparam logic [7:0] CMD_BREAK   = 8'h42;
    localparam logic [7:0] CMD_CLEAR   = 8'h43;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_ERR     = 8'h21;
    localparam logic [7:0] RSP_UNK     = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_BREAK   = 8'h58;

    localparam int TX_DEPTH = 3;

    typedef enum logic [2:0] {
        IDLE, ARG_HI, ARG_LO, WAIT_HALT, WAIT_STEP, SEND
`ifdef DEBUG_PC_REPORT_EN
        , SEND_PCH, SEND_PCL
`endif
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_WAIT_HI, TX_WAIT_LO
    } tx_phase_t;

    typedef struct packed {
        state_t    ctrl;
        tx_phase_t tx;
    } dbg_t;

endpackage

// File: rtl/debug_tx_seq.sv
// Response byte queue (3 deep) and the tx_start / tx_busy handshake to uart_tx.
// At most one byte is in flight: the next tx_start waits for tx_busy to rise and fall.
module debug_tx_seq
    import debug_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push_valid,
    input  logic [7:0] push_byte,
    input  logic      tx_busy,
    output logic      tx_start,
    output logic [7:0] tx_byte,
    output logic      idle,
    output tx_phase_t phase
);

    // push_valid has no ready: the caller pushes only while idle, so a push is never refused
    // in practice; a push into a full queue is dropped rather than overwriting.
    tx_phase_t  phase_q, phase_d;
    logic       start_q, start_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] mem_q [TX_DEPTH];
    logic [7:0] mem_d [TX_DEPTH];
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    always_comb begin
        phase_d = phase_q;
        start_d = 1'b0;
        byte_d  = byte_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (phase_q)
            TX_IDLE: begin
                if (cnt_q != 2'd0 && !tx_busy) begin
                    start_d = 1'b1;
                    byte_d  = mem_q[0];
                    pop     = 1'b1;
                    phase_d = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: if (tx_busy)  phase_d = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_busy) phase_d = TX_IDLE;
            default:    phase_d = TX_IDLE;
        endcase
        if (pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push_valid && cnt_d != 2'(TX_DEPTH)) begin
            mem_d[cnt_d] = push_byte;
            cnt_d        = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= TX_IDLE;
            start_q <= 1'b0;
            byte_q  <= 8'h00;
            cnt_q   <= 2'd0;
            for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            phase_q <= phase_d;
            start_q <= start_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign tx_start = start_q;
    assign tx_byte  = byte_q;
    assign idle     = (phase_q == TX_IDLE) && (cnt_q == 2'd0);
    assign phase    = phase_q;

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Serial debug command sequencer: halt/resume/step, one PC breakpoint, one status byte per command.
// DEBUG_PC_REPORT_EN appends cpu_pc (high byte first) after a completed halt or step.
module debug_cmd_ctrl
    import debug_pkg::*;
#(
    parameter int HALT_TIMEOUT = 1048576,
    parameter int TO_W         = 21
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic [15:0] cpu_pc,
    input  logic        cpu_halted,
    input  logic        cpu_step_done,
    input  logic        tx_busy,
    output logic        halt,
    output logic        step,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic        break_en,
    output logic [15:0] break_addr,
    output logic        overrun,
    output dbg_t        dbg_state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            halt_q, halt_d, step_q, step_d, ovr_q, ovr_d;
    logic            brk_en_q, brk_en_d, bp_q, bp_d;
    logic [15:0]     brk_addr_q, brk_addr_d;
    logic [7:0]      arg_hi_q, arg_hi_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            push_valid, tx_idle;
    logic [7:0]      push_byte;
    tx_phase_t       tx_phase;
`ifdef DEBUG_PC_REPORT_EN
    logic [15:0]     pc_q, pc_d;
    logic            pc_pend_q, pc_pend_d;
`endif

    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        step_d     = 1'b0;
        ovr_d      = 1'b0;
        brk_en_d   = brk_en_q;
        brk_addr_d = brk_addr_q;
        arg_hi_d   = arg_hi_q;
        bp_d       = bp_q;
        to_cnt_d   = to_cnt_q;
        push_valid = 1'b0;
        push_byte  = RSP_OK;
`ifdef DEBUG_PC_REPORT_EN
        pc_d       = pc_q;
        pc_pend_d  = pc_pend_q;
`endif
        case (state_q)
            IDLE: begin
                // A breakpoint hit outranks a byte arriving in the same cycle.
                if (brk_en_q && !halt_q && cpu_pc == brk_addr_q) begin
                    halt_d  = 1'b1;
                    bp_d    = 1'b1;
                    ovr_d   = rx_valid;
                    state_d = WAIT_HALT;
                end else if (rx_valid) begin
                    case (rx_byte)
                        CMD_HALT: begin
                            halt_d = 1'b1;
                            bp_d   = 1'b0;
                            if (cpu_halted) begin
                                push_valid = 1'b1;
                                state_d    = SEND;
                            end else begin
                                state_d = WAIT_HALT;
                            end
                        end
                        CMD_RESUME: begin
                            halt_d     = 1'b0;
                            push_valid = 1'b1;
                            state_d    = SEND;
                        end
                        CMD_STEP: begin
                            if (!halt_q || !cpu_halted) begin
                                push_valid = 1'b1;
                                push_byte  = RSP_ERR;
                                state_d    = SEND;
                            end else begin
                                step_d  = 1'b1;
                                state_d = WAIT_STEP;
                            end
                        end
                        CMD_BREAK: state_d = ARG_HI;
                        CMD_CLEAR: begin
                            brk_en_d   = 1'b0;
                            push_valid = 1'b1;
                            state_d    = SEND;
                        end
                        default: begin
                            push_valid = 1'b1;
                            push_byte  = RSP_UNK;
                            state_d    = SEND;
                        end
                    endcase
                end
            end
            ARG_HI: begin
                if (rx_valid) begin
                    arg_hi_d = rx_byte;
                    state_d  = ARG_LO;
                end
            end
            ARG_LO: begin
                if (rx_valid) begin
                    brk_addr_d = {arg_hi_q, rx_byte};
                    brk_en_d   = 1'b1;
                    push_valid = 1'b1;
                    state_d    = SEND;
                end
            end
            WAIT_HALT, WAIT_STEP: begin
                ovr_d = rx_valid;
                if ((state_q == WAIT_HALT) ? cpu_halted : cpu_step_done) begin
                    push_valid = 1'b1;
                    push_byte  = (state_q == WAIT_HALT && bp_q) ? RSP_BREAK : RSP_OK;
                    to_cnt_d   = '0;
                    state_d    = SEND;
`ifdef DEBUG_PC_REPORT_EN
                    pc_d      = cpu_pc;
                    pc_pend_d = 1'b1;
`endif
                end else if (to_cnt_q == TO_LAST) begin
                    push_valid = 1'b1;
                    push_byte  = RSP_TIMEOUT;
                    to_cnt_d   = '0;
                    state_d    = SEND;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            SEND: begin
                ovr_d = rx_valid;
                if (tx_idle) begin
`ifdef DEBUG_PC_REPORT_EN
                    if (pc_pend_q) begin
                        push_valid = 1'b1;
                        push_byte  = pc_q[15:8];
                        state_d    = SEND_PCH;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef DEBUG_PC_REPORT_EN
            SEND_PCH: begin
                ovr_d = rx_valid;
                if (tx_idle) begin
                    push_valid = 1'b1;
                    push_byte  = pc_q[7:0];
                    state_d    = SEND_PCL;
                end
            end
            SEND_PCL: begin
                ovr_d = rx_valid;
                if (tx_idle) begin
                    pc_pend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            halt_q     <= 1'b0;
            step_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_en_q   <= 1'b0;
            brk_addr_q <= 16'h0000;
            arg_hi_q   <= 8'h00;
            bp_q       <= 1'b0;
            to_cnt_q   <= '0;
`ifdef DEBUG_PC_REPORT_EN
            pc_q       <= 16'h0000;
            pc_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            step_q     <= step_d;
            ovr_q      <= ovr_d;
            brk_en_q   <= brk_en_d;
            brk_addr_q <= brk_addr_d;
            arg_hi_q   <= arg_hi_d;
            bp_q       <= bp_d;
            to_cnt_q   <= to_cnt_d;
`ifdef DEBUG_PC_REPORT_EN
            pc_q       <= pc_d;
            pc_pend_q  <= pc_pend_d;
`endif
        end
    end

    debug_tx_seq u_tx_seq (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_byte  (push_byte),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .idle       (tx_idle),
        .phase      (tx_phase)
    );

    assign halt       = halt_q;
    assign step       = step_q;
    assign overrun    = ovr_q;
    assign break_en   = brk_en_q;
    assign break_addr = brk_addr_q;
    assign dbg_state  = '{ctrl: state_q, tx: tx_phase};

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Scoreboarded bench for debug_cmd_ctrl with a small uart_tx busy model and CPU stimulus.
module tb_debug_cmd_ctrl;
  import debug_pkg::*;

  logic        clk, reset, rx_valid, cpu_halted, cpu_step_done, tx_busy;
  logic [7:0]  rx_byte;
  logic [15:0] cpu_pc;
  logic        halt, step, tx_start, break_en, overrun;
  logic [7:0]  tx_byte;
  logic [15:0] break_addr;
  dbg_t        dbg_state;

  logic [7:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;
  int tx_starts = 0, step_cnt = 0, ovr_cnt = 0;

  debug_cmd_ctrl #(.HALT_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cpu_pc(cpu_pc), .cpu_halted(cpu_halted), .cpu_step_done(cpu_step_done),
    .tx_busy(tx_busy), .halt(halt), .step(step), .tx_start(tx_start),
    .tx_byte(tx_byte), .break_en(break_en), .break_addr(break_addr),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // uart_tx model: busy rises the cycle after tx_start, stays busy 3 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if (tx_start === 1'b1) begin
        #1 tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // scoreboard: every tx_start pops one expected byte
  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (tx_start === 1'b1) begin
      tx_starts++;
      total_cnt++;
      if (exp_q.size() == 0)
        $display("FAIL tx_unexpected: got byte %02h, required no transmission", tx_byte);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_byte !== e) $display("FAIL tx_byte: got %02h, required %02h", tx_byte, e);
        else pass_cnt++;
      end
      total_cnt++;
      if (tx_busy !== 1'b0) $display("FAIL tx_overlap: tx_start while tx_busy=%b, required 0", tx_busy);
      else pass_cnt++;
    end
  end

  // driver tasks
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic exp_pc(input logic [15:0] pc);
`ifdef DEBUG_PC_REPORT_EN
    exp_q.push_back(pc[15:8]);
    exp_q.push_back(pc[7:0]);
`endif
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state.ctrl != IDLE || tx_busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= 300) $display("FAIL %s_drain: %0d bytes still expected, state %0d, required 0 and IDLE",
                           name, exp_q.size(), dbg_state.ctrl);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic measure_latency(input string name, input int req);
    int n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n != req) $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, req);
    else pass_cnt++;
  endtask

  // tests
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({halt, step, tx_start, tx_byte, break_en, break_addr, overrun} !== 29'd0)
      $display("FAIL reset_outputs: got %b, required all zero",
               {halt, step, tx_start, tx_byte, break_en, break_addr, overrun});
    else pass_cnt++;
    total_cnt++;
    if (dbg_state.ctrl !== IDLE) $display("FAIL reset_state: got %0d, required IDLE", dbg_state.ctrl);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt;
    int s0 = tx_starts;
    exp_q.push_back(RSP_OK);
    exp_pc(cpu_pc);
    send_rx(CMD_HALT);
    total_cnt++;
    if (halt !== 1'b1) $display("FAIL halt_level: got %b, required 1", halt);
    else pass_cnt++;
    repeat (9) @(negedge clk);
    cpu_halted = 1'b1;
    wait_drain("halt");
`ifdef DEBUG_PC_REPORT_EN
    s0 = s0 + 2;
`endif
    total_cnt++;
    if (tx_starts - s0 != 1) $display("FAIL halt_starts: got %0d tx_start, required 1", tx_starts - s0);
    else pass_cnt++;
  endtask

  task automatic test_step;
    int sc;
    exp_q.push_back(RSP_OK);
    exp_pc(cpu_pc);
    sc = step_cnt;
    send_rx(CMD_STEP);
    total_cnt++;
    if (step !== 1'b1) $display("FAIL step_pulse: got %b, required 1", step);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (step !== 1'b0) $display("FAIL step_width: got %b, required 0", step);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    cpu_step_done = 1'b1;
    @(negedge clk);
    cpu_step_done = 1'b0;
    wait_drain("step");
    exp_q.push_back(RSP_OK);
    send_rx(CMD_RESUME);
    measure_latency("resume", 1);
    wait_drain("resume");
    total_cnt++;
    if (halt !== 1'b0) $display("FAIL resume_halt: got %b, required 0", halt);
    else pass_cnt++;
    cpu_halted = 1'b0;
    exp_q.push_back(RSP_ERR);
    send_rx(CMD_STEP);
    wait_drain("step_err");
    total_cnt++;
    if (step_cnt - sc != 1) $display("FAIL step_count: got %0d pulses, required 1", step_cnt - sc);
    else pass_cnt++;
  endtask

  task automatic test_break;
    cpu_pc = 16'h0000;
    exp_q.push_back(RSP_OK);
    send_rx(CMD_BREAK);
    send_rx(8'h01);
    send_rx(8'h50);
    wait_drain("break_set");
    total_cnt++;
    if ({break_en, break_addr} !== {1'b1, 16'h0150})
      $display("FAIL break_arm: got en=%b addr=%04h, required en=1 addr=0150", break_en, break_addr);
    else pass_cnt++;
    exp_q.push_back(RSP_BREAK);
    exp_pc(16'h0150);
    cpu_pc = 16'h0150;
    @(negedge clk);
    total_cnt++;
    if (halt !== 1'b1) $display("FAIL break_halt: got %b, required 1", halt);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    cpu_halted = 1'b1;
    wait_drain("break_hit");
    exp_q.push_back(RSP_OK);
    send_rx(CMD_CLEAR);
    wait_drain("clear");
    total_cnt++;
    if (break_en !== 1'b0) $display("FAIL clear_en: got %b, required 0", break_en);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    cpu_halted = 1'b0;
    exp_q.push_back(RSP_TIMEOUT);
    send_rx(CMD_HALT);
    measure_latency("timeout", 17);
    wait_drain("timeout");
    total_cnt++;
    if (halt !== 1'b1) $display("FAIL timeout_halt: got %b, required 1", halt);
    else pass_cnt++;
  endtask

  task automatic test_overrun;
    int oc = ovr_cnt;
    cpu_pc = 16'h2468;
    exp_q.push_back(RSP_OK);
    exp_pc(16'h2468);
    send_rx(CMD_HALT);
    send_rx(CMD_RESUME);
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b, required 1", overrun);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    cpu_halted = 1'b1;
    wait_drain("overrun");
    total_cnt++;
    if (halt !== 1'b1 || ovr_cnt - oc != 1)
      $display("FAIL overrun_drop: got halt=%b pulses=%0d, required halt=1 pulses=1", halt, ovr_cnt - oc);
    else pass_cnt++;
  endtask

  task automatic test_unknown;
    exp_q.push_back(RSP_UNK);
    send_rx(8'h7A);
    measure_latency("unknown", 1);
    wait_drain("unknown");
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    cpu_halted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0: begin b = CMD_RESUME; exp_q.push_back(RSP_OK); end
        1: begin b = CMD_CLEAR;  exp_q.push_back(RSP_OK); end
        default: begin b = 8'($urandom_range(8'h60, 8'h7F)); exp_q.push_back(RSP_UNK); end
      endcase
      send_rx(b);
      measure_latency("b2b", 1);
      wait_drain("b2b");
    end
  endtask

  task automatic test_pc_report;
    exp_q.push_back(RSP_OK);
    exp_pc(16'hC3A0);
    cpu_pc = 16'hC3A0;
    send_rx(CMD_HALT);
    repeat (4) @(negedge clk);
    cpu_halted = 1'b1;
    wait_drain("pc_report");
  endtask

  task automatic test_reset_mid;
    int s0;
    send_rx(CMD_STEP);
    @(negedge clk);
    total_cnt++;
    if (dbg_state.ctrl !== WAIT_STEP) $display("FAIL mid_state: got %0d, required WAIT_STEP", dbg_state.ctrl);
    else pass_cnt++;
    s0 = tx_starts;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({halt, step, tx_start, tx_byte, break_en, break_addr, overrun} !== 29'd0 || dbg_state.ctrl !== IDLE)
      $display("FAIL mid_reset: got %b state %0d, required all zero and IDLE",
               {halt, step, tx_start, tx_byte, break_en, break_addr, overrun}, dbg_state.ctrl);
    else pass_cnt++;
    reset = 1'b0;
    cpu_step_done = 1'b1;
    @(negedge clk);
    cpu_step_done = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (tx_starts != s0) $display("FAIL mid_no_tx: got %0d tx_start, required 0", tx_starts - s0);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    cpu_pc = 16'h1234; cpu_halted = 1'b0; cpu_step_done = 1'b0;
    test_reset;
    test_halt;
    test_step;
    test_break;
    test_timeout;
    test_overrun;
    test_unknown;
    test_back_to_back;
    test_pc_report;
    test_reset_mid;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d bytes pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
